commit_ctrl: RTL and testbench

- Retirement scheduler for the 4-wide commit datapath.
- Owns the ROB head pointer and reads the 4 oldest ROB entries each cycle.
- Selects the in-order committable prefix and drives the registered commit bus: rat_write_en, rat_write_addr_0..3, rat_write_data_0..3 and reg_write_data_0..3. It also drives free-list releases.
- Sequences exception flushes and ebreak halt.

---
 rtl/commit_ctrl_if.sv | 68 ++++++
 rtl/commit_ctrl.sv | 166 ++++++++++++++++
 tb/tb_commit_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/commit_ctrl_if.sv
// commit_ctrl_if: bundles the ROB-side read port and the commit-side output
// bus of the retirement scheduler.
//   ROB side    : rob_count, rob_head, ent_* lane fields (4 oldest entries),
//                 commit_hold
//   Commit side : rat_write_en/addr/data, reg_write_data, free_valid/preg,
//                 commit_cnt, flush, flush_pc, halt
// master = commit_ctrl (consumes ROB lanes, drives the commit bus)
// slave  = ROB / rename / debug environment
interface commit_ctrl_if #(
    parameter int unsigned ROB_DEPTH = 32,
    parameter int unsigned PREG_W    = 7,
    parameter int unsigned AREG_W    = 5
);
    localparam int unsigned HEAD_W = $clog2(ROB_DEPTH);

    logic [HEAD_W:0]     rob_count;
    logic [HEAD_W-1:0]   rob_head;
    logic [3:0]          ent_ready;
    logic [3:0]          ent_rd_we;
    logic [4*AREG_W-1:0] ent_areg;
    logic [4*PREG_W-1:0] ent_preg;
    logic [4*PREG_W-1:0] ent_old_preg;
    logic [127:0]        ent_data;
    logic [3:0]          ent_exc;
    logic [3:0]          ent_halt;
    logic [127:0]        ent_pc;
    logic                commit_hold;

    logic [7:0]          rat_write_en;
    logic [7:0]          rat_write_addr_0;
    logic [7:0]          rat_write_addr_1;
    logic [7:0]          rat_write_addr_2;
    logic [7:0]          rat_write_addr_3;
    logic [7:0]          rat_write_data_0;
    logic [7:0]          rat_write_data_1;
    logic [7:0]          rat_write_data_2;
    logic [7:0]          rat_write_data_3;
    logic [31:0]         reg_write_data_0;
    logic [31:0]         reg_write_data_1;
    logic [31:0]         reg_write_data_2;
    logic [31:0]         reg_write_data_3;
    logic [3:0]          free_valid;
    logic [4*PREG_W-1:0] free_preg;
    logic [2:0]          commit_cnt;
    logic                flush;
    logic [31:0]         flush_pc;
    logic                halt;

    modport master (
        input  rob_count, ent_ready, ent_rd_we, ent_areg, ent_preg,
               ent_old_preg, ent_data, ent_exc, ent_halt, ent_pc, commit_hold,
        output rob_head, rat_write_en,
               rat_write_addr_0, rat_write_addr_1, rat_write_addr_2, rat_write_addr_3,
               rat_write_data_0, rat_write_data_1, rat_write_data_2, rat_write_data_3,
               reg_write_data_0, reg_write_data_1, reg_write_data_2, reg_write_data_3,
               free_valid, free_preg, commit_cnt, flush, flush_pc, halt
    );

    modport slave (
        output rob_count, ent_ready, ent_rd_we, ent_areg, ent_preg,
               ent_old_preg, ent_data, ent_exc, ent_halt, ent_pc, commit_hold,
        input  rob_head, rat_write_en,
               rat_write_addr_0, rat_write_addr_1, rat_write_addr_2, rat_write_addr_3,
               rat_write_data_0, rat_write_data_1, rat_write_data_2, rat_write_data_3,
               reg_write_data_0, reg_write_data_1, reg_write_data_2, reg_write_data_3,
               free_valid, free_preg, commit_cnt, flush, flush_pc, halt
    );
endinterface

// File: rtl/commit_ctrl.sv
// commit_ctrl: 4-wide in-order retirement scheduler.
// Owns the ROB head pointer, scans the 4 oldest entries, retires the
// committable in-order prefix onto a registered commit bus, releases old
// physical registers, and sequences exception flush and ebreak halt.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - commit_ctrl_if.master: ROB lanes in, commit bus / flush / halt out
module commit_ctrl #(
    parameter int unsigned ROB_DEPTH = 32,
    parameter int unsigned PREG_W    = 7,
    parameter int unsigned AREG_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    commit_ctrl_if.master   bus
);
    localparam int unsigned HEAD_W = $clog2(ROB_DEPTH);
    localparam int unsigned CNT_W  = HEAD_W + 1;

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

    state_t              r_state;
    logic [HEAD_W-1:0]   r_head;
    logic [3:0]          r_rat_we;
    logic [7:0]          r_rat_addr [4];
    logic [7:0]          r_rat_data [4];
    logic [31:0]         r_reg_data [4];
    logic [3:0]          r_free_valid;
    logic [4*PREG_W-1:0] r_free_preg;
    logic [2:0]          r_commit_cnt;
    logic                r_flush;
    logic [31:0]         r_flush_pc;
    logic                r_halt;

    logic [2:0]          w_n;
    logic [3:0]          w_commit;
    logic [3:0]          w_wr;
    logic                w_exc;
    logic                w_halt_hit;
    logic                w_stop;
    logic [31:0]         w_exc_pc;

    // In-order prefix scan: an exception lane stops the scan uncommitted,
    // an ebreak lane is committed and then stops the scan.
    always_comb begin
        w_n        = '0;
        w_commit   = '0;
        w_wr       = '0;
        w_exc      = 1'b0;
        w_halt_hit = 1'b0;
        w_stop     = 1'b0;
        w_exc_pc   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!w_stop) begin
                if (CNT_W'(i) >= bus.rob_count || !bus.ent_ready[i]) begin
                    w_stop = 1'b1;
                end else if (bus.ent_exc[i]) begin
                    w_exc    = 1'b1;
                    w_exc_pc = bus.ent_pc[i*32 +: 32];
                    w_stop   = 1'b1;
                end else begin
                    w_commit[i] = 1'b1;
                    w_n         = w_n + 3'd1;
                    if (bus.ent_halt[i]) begin
                        w_halt_hit = 1'b1;
                        w_stop     = 1'b1;
                    end
                end
            end
        end
        // x0 writes retire but never touch the RAT or free list
        for (int unsigned i = 0; i < 4; i++) begin
            w_wr[i] = w_commit[i] & bus.ent_rd_we[i] & (|bus.ent_areg[i*AREG_W +: AREG_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_head       <= '0;
            r_rat_we     <= '0;
            r_free_valid <= '0;
            r_free_preg  <= '0;
            r_commit_cnt <= '0;
            r_flush      <= 1'b0;
            r_flush_pc   <= '0;
            r_halt       <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_rat_addr[i] <= '0;
                r_rat_data[i] <= '0;
                r_reg_data[i] <= '0;
            end
        end else begin
            // Commit bus and flush are pulses; cleared unless re-selected below.
            r_rat_we     <= '0;
            r_free_valid <= '0;
            r_free_preg  <= '0;
            r_commit_cnt <= '0;
            r_flush      <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_rat_addr[i] <= '0;
                r_rat_data[i] <= '0;
                r_reg_data[i] <= '0;
            end

            unique case (r_state)
                S_RUN: begin
                    if (!bus.commit_hold) begin
                        r_rat_we     <= w_wr;
                        r_free_valid <= w_wr;
                        r_commit_cnt <= w_n;
                        r_head       <= r_head + HEAD_W'(w_n);
                        for (int unsigned i = 0; i < 4; i++) begin
                            if (w_wr[i]) begin
                                r_rat_addr[i] <= 8'(bus.ent_areg[i*AREG_W +: AREG_W]);
                                r_rat_data[i] <= 8'(bus.ent_preg[i*PREG_W +: PREG_W]);
                                r_reg_data[i] <= bus.ent_data[i*32 +: 32];
                                r_free_preg[i*PREG_W +: PREG_W] <= bus.ent_old_preg[i*PREG_W +: PREG_W];
                            end
                        end
                        if (w_exc) begin
                            r_state    <= S_FLUSH;
                            r_flush_pc <= w_exc_pc;
                        end else if (w_halt_hit) begin
                            r_state <= S_HALT;
                            r_halt  <= 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    r_flush <= 1'b1;
                    r_head  <= '0;
                    r_state <= S_RUN;
                end
                S_HALT: begin
                    r_halt <= 1'b1;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign bus.rob_head         = r_head;
    assign bus.rat_write_en     = {4'b0000, r_rat_we};
    assign bus.rat_write_addr_0 = r_rat_addr[0];
    assign bus.rat_write_addr_1 = r_rat_addr[1];
    assign bus.rat_write_addr_2 = r_rat_addr[2];
    assign bus.rat_write_addr_3 = r_rat_addr[3];
    assign bus.rat_write_data_0 = r_rat_data[0];
    assign bus.rat_write_data_1 = r_rat_data[1];
    assign bus.rat_write_data_2 = r_rat_data[2];
    assign bus.rat_write_data_3 = r_rat_data[3];
    assign bus.reg_write_data_0 = r_reg_data[0];
    assign bus.reg_write_data_1 = r_reg_data[1];
    assign bus.reg_write_data_2 = r_reg_data[2];
    assign bus.reg_write_data_3 = r_reg_data[3];
    assign bus.free_valid       = r_free_valid;
    assign bus.free_preg        = r_free_preg;
    assign bus.commit_cnt       = r_commit_cnt;
    assign bus.flush            = r_flush;
    assign bus.flush_pc         = r_flush_pc;
    assign bus.halt             = r_halt;
endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl: randomized scoreboard bench for commit_ctrl.
// A queue-based ROB model supplies entries; the expected commit bus for each
// clock edge is pushed into a scoreboard and a separate monitor compares.
module tb_commit_ctrl;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned PREG_W = 7;
    localparam int unsigned AREG_W = 5;
    localparam int          NCYC   = 4000;

    typedef struct {
        logic        ready;
        logic        rd_we;
        logic [4:0]  areg;
        logic [6:0]  preg;
        logic [6:0]  old_preg;
        logic [31:0] data;
        logic        exc;
        logic        halt;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic [2:0]   cnt;
        logic [7:0]   we;
        logic [31:0]  addr;
        logic [31:0]  rdata;
        logic [127:0] rwd;
        logic [3:0]   fv;
        logic [27:0]  fpreg;
        logic         flush;
        logic [31:0]  fpc;
        logic         halt;
        logic [4:0]   head;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    commit_ctrl_if #(.ROB_DEPTH(DEPTH), .PREG_W(PREG_W), .AREG_W(AREG_W)) bus ();

    commit_ctrl #(.ROB_DEPTH(DEPTH), .PREG_W(PREG_W), .AREG_W(AREG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Monitor: one expected record per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL scoreboard_empty at %0t: got none expected record", $time);
            end else begin
                e = exp_q.pop_front();
                chk("commit_cnt", 128'(bus.commit_cnt), 128'(e.cnt));
                chk("rat_write_en", 128'(bus.rat_write_en), 128'(e.we));
                chk("rat_write_addr", 128'({bus.rat_write_addr_3, bus.rat_write_addr_2,
                                            bus.rat_write_addr_1, bus.rat_write_addr_0}), 128'(e.addr));
                chk("rat_write_data", 128'({bus.rat_write_data_3, bus.rat_write_data_2,
                                            bus.rat_write_data_1, bus.rat_write_data_0}), 128'(e.rdata));
                chk("reg_write_data", {bus.reg_write_data_3, bus.reg_write_data_2,
                                       bus.reg_write_data_1, bus.reg_write_data_0}, e.rwd);
                chk("free_valid", 128'(bus.free_valid), 128'(e.fv));
                chk("free_preg", 128'(bus.free_preg), 128'(e.fpreg));
                chk("flush", 128'(bus.flush), 128'(e.flush));
                if (e.flush) chk("flush_pc", 128'(bus.flush_pc), 128'(e.fpc));
                chk("halt", 128'(bus.halt), 128'(e.halt));
                chk("rob_head", 128'(bus.rob_head), 128'(e.head));
            end
        end
    end

    // Reference model state
    ent_t        rq[$];
    int          m_head;
    bit          m_flush_pend;
    bit          m_flush_vis;
    bit          m_halted;
    logic [31:0] m_fpc;
    int          halt_cycles;

    function automatic ent_t new_ent();
        ent_t en;
        en.ready    = ($urandom_range(0, 1) == 1);
        en.rd_we    = ($urandom_range(0, 3) != 0);
        en.areg     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        en.preg     = 7'($urandom);
        en.old_preg = 7'($urandom);
        en.data     = $urandom;
        en.exc      = ($urandom_range(0, 19) == 0);
        en.halt     = ($urandom_range(0, 79) == 0);
        en.pc       = $urandom;
        return en;
    endfunction

    initial begin
        exp_t        e;
        ent_t        en;
        bit          do_rst;
        bit          hold;
        int          n;
        int          ev;
        int          nalloc;
        logic [3:0]  v_ready, v_we, v_exc, v_halt;
        logic [19:0] v_areg;
        logic [27:0] v_preg, v_old;
        logic [127:0] v_data, v_pc;

        m_head = 0; m_flush_pend = 0; m_flush_vis = 0; m_halted = 0;
        m_fpc = '0; halt_cycles = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            do_rst = (cyc < 3) || (m_halted && halt_cycles > 8) ||
                     (m_flush_pend && $urandom_range(0, 3) == 0) ||
                     ($urandom_range(0, 299) == 0);
            hold   = ($urandom_range(0, 7) == 0);

            // ROB allocation; the ROB is empty in the cycle flush is visible
            if (m_flush_vis) begin
                m_flush_vis = 0;
            end else if (!do_rst) begin
                nalloc = $urandom_range(0, 3);
                for (int j = 0; j < nalloc; j++)
                    if (rq.size() < DEPTH) rq.push_back(new_ent());
            end
            // Completion of older in-flight entries
            for (int j = 0; j < 4 && j < rq.size(); j++)
                if (!rq[j].ready && $urandom_range(0, 1) == 1) rq[j].ready = 1'b1;

            // Present the 4 oldest entries; lanes past the count carry junk
            for (int j = 0; j < 4; j++) begin
                en = (j < rq.size()) ? rq[j] : new_ent();
                v_ready[j] = en.ready;
                v_we[j]    = en.rd_we;
                v_exc[j]   = en.exc;
                v_halt[j]  = en.halt;
                v_areg[j*5 +: 5]  = en.areg;
                v_preg[j*7 +: 7]  = en.preg;
                v_old[j*7 +: 7]   = en.old_preg;
                v_data[j*32 +: 32] = en.data;
                v_pc[j*32 +: 32]   = en.pc;
            end
            rst                = do_rst;
            bus.commit_hold    = hold;
            bus.rob_count      = 6'(rq.size());
            bus.ent_ready      = v_ready;
            bus.ent_rd_we      = v_we;
            bus.ent_exc        = v_exc;
            bus.ent_halt       = v_halt;
            bus.ent_areg       = v_areg;
            bus.ent_preg       = v_preg;
            bus.ent_old_preg   = v_old;
            bus.ent_data       = v_data;
            bus.ent_pc         = v_pc;

            // Expected outputs after the coming edge
            e = '{default: '0};
            if (do_rst) begin
                rq.delete();
                m_head = 0; m_flush_pend = 0; m_flush_vis = 0; m_halted = 0;
                halt_cycles = 0;
            end else if (m_flush_pend) begin
                e.flush = 1'b1;
                e.fpc   = m_fpc;
                m_head  = 0;
                m_flush_pend = 0;
                m_flush_vis  = 1;
                rq.delete();
            end else if (m_halted) begin
                halt_cycles++;
            end else if (!hold) begin
                n = 0; ev = 0;
                for (int j = 0; j < 4 && j < rq.size(); j++) begin
                    if (!rq[j].ready) break;
                    if (rq[j].exc) begin ev = 1; break; end
                    n++;
                    if (rq[j].halt) begin ev = 2; break; end
                end
                for (int j = 0; j < n; j++) begin
                    if (rq[j].rd_we && rq[j].areg != 5'd0) begin
                        e.we[j]              = 1'b1;
                        e.fv[j]              = 1'b1;
                        e.addr[j*8 +: 8]     = {3'b000, rq[j].areg};
                        e.rdata[j*8 +: 8]    = {1'b0, rq[j].preg};
                        e.rwd[j*32 +: 32]    = rq[j].data;
                        e.fpreg[j*7 +: 7]    = rq[j].old_preg;
                    end
                end
                e.cnt = 3'(n);
                if (ev == 1) begin
                    m_fpc = rq[n].pc;
                    m_flush_pend = 1;
                end else if (ev == 2) begin
                    m_halted = 1;
                    halt_cycles = 0;
                end
                for (int j = 0; j < n; j++) void'(rq.pop_front());
                m_head = (m_head + n) % DEPTH;
            end
            e.head = 5'(m_head);
            e.halt = m_halted;
            exp_q.push_back(e);

            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
